// File: rtl/ddr_rx_word_packer.sv
// Packs HDR-DDR rx data bytes into parity-checked 16-bit words, queues them in a small FIFO,
// and checks the frame CRC5 (x^5+x^2+1, init 5'h1F, MSB first) at frame end.
module ddr_rx_word_packer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_frame_start,
    input  logic        i_abort,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    input  logic        i_par_valid,
    input  logic [1:0]  i_par,
    input  logic        i_crc_valid,
    input  logic [4:0]  i_crc,
    input  logic        i_word_ready,
    output logic        o_word_valid,
    output logic [15:0] o_word_data,
    output logic        o_word_par_err,
    output logic [4:0]  o_crc_value,
    output logic        o_par_err,
    output logic        o_crc_err,
    output logic        o_proto_err,
    output logic        o_overflow,
    output logic        o_frame_done,
    output logic [2:0]  dbg_state
);

    // Read side handshake: the head word transfers on any cycle where
    // o_word_valid and i_word_ready are both high; o_word_valid never drops without a pop or abort.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_PAR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0]      CRC_INIT = 5'h1F;
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t state;
    logic [7:0]  hi_byte;
    logic [7:0]  lo_byte;
    logic [4:0]  crc;
    logic        push_pend;
    logic [16:0] push_entry;

    logic [16:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic        acc_byte;
    logic        acc_par;
    logic        acc_crc;
    logic        proto;
    logic [15:0] word;
    logic [1:0]  exp_par;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_wr;

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'h05;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        acc_byte  = i_byte_valid && (state == S_HI || state == S_LO);
        acc_crc   = i_crc_valid && (state == S_HI) && !acc_byte;
        acc_par   = i_par_valid && (state == S_PAR);
        proto     = (i_byte_valid && !acc_byte) || (i_par_valid && !acc_par) ||
                    (i_crc_valid && !acc_crc);
        word      = {hi_byte, lo_byte};
        exp_par   = {^(word & 16'hAAAA), ~^(word & 16'h5555)};
        fifo_pop  = (count != '0) && i_word_ready;
        fifo_full = (count == CNT_FULL);
        fifo_wr   = push_pend && (!fifo_full || fifo_pop);
    end

    // Storage is not reset; the output side is gated by o_word_valid instead.
    always_ff @(posedge i_sys_clk) begin
        if (fifo_wr) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state        <= S_IDLE;
            hi_byte      <= '0;
            lo_byte      <= '0;
            crc          <= CRC_INIT;
            push_pend    <= 1'b0;
            push_entry   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_par_err    <= 1'b0;
            o_crc_err    <= 1'b0;
            o_proto_err  <= 1'b0;
            o_overflow   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_par_err    <= 1'b0;
            o_crc_err    <= 1'b0;
            o_proto_err  <= 1'b0;
            o_frame_done <= 1'b0;
            push_pend    <= 1'b0;

            // Clear precedes the FIFO update so a same-cycle drop still leaves the flag set.
            if (!i_abort && i_frame_start) o_overflow <= 1'b0;

            if (i_abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;
                if (push_pend && fifo_full && !fifo_pop) o_overflow <= 1'b1;
                if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
                if (fifo_wr && !fifo_pop)      count <= count + CNT_ONE;
                else if (!fifo_wr && fifo_pop) count <= count - CNT_ONE;
            end

            if (i_abort) begin
                state <= S_IDLE;
                crc   <= CRC_INIT;
            end else if (i_frame_start) begin
                state <= S_HI;
                crc   <= CRC_INIT;
            end else begin
                o_proto_err <= proto;
                case (state)
                    S_HI: begin
                        if (acc_byte) begin
                            hi_byte <= i_byte;
                            crc     <= crc5_byte(crc, i_byte);
                            state   <= S_LO;
                        end else if (acc_crc) begin
                            o_crc_err    <= (i_crc != crc);
                            o_frame_done <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                    S_LO: begin
                        if (acc_byte) begin
                            lo_byte <= i_byte;
                            crc     <= crc5_byte(crc, i_byte);
                            state   <= S_PAR;
                        end
                    end
                    S_PAR: begin
                        if (acc_par) begin
                            o_par_err  <= (i_par != exp_par);
                            push_pend  <= 1'b1;
                            push_entry <= {(i_par != exp_par), word};
                            state      <= S_HI;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_word_valid   = (count != '0);
    assign o_word_data    = o_word_valid ? mem[rd_ptr][15:0] : 16'h0000;
    assign o_word_par_err = o_word_valid ? mem[rd_ptr][16] : 1'b0;
    assign o_crc_value    = crc;
    assign dbg_state      = state;

endmodule
